// File: rtl/multicycle_control_fsm_pkg.sv
// Shared control definitions for the 16-bit multicycle datapath:
// opcode values, FSM state encodings, ALUop codes, mux select encodings
// and the bundle of datapath control signals.
package ctrl_pkg;

  localparam int OPCODE_W = 4;
  localparam int STATE_W  = 4;

  // Opcode field IR[15:12]; 8-15 are undefined
  localparam logic [3:0] OP_RTYPE = 4'd0;
  localparam logic [3:0] OP_ADDI  = 4'd1;
  localparam logic [3:0] OP_LW    = 4'd2;
  localparam logic [3:0] OP_SW    = 4'd3;
  localparam logic [3:0] OP_BEQ   = 4'd4;
  localparam logic [3:0] OP_BNE   = 4'd5;
  localparam logic [3:0] OP_J     = 4'd6;
  localparam logic [3:0] OP_ORI   = 4'd7;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_ALU_WB   = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_RST      = 4'd15
  } state_t;

  // ALUop codes understood by the ALU control decoder
  localparam logic [1:0] ALUOP_ADD  = 2'd0;
  localparam logic [1:0] ALUOP_SUB  = 2'd1;
  localparam logic [1:0] ALUOP_FUNC = 2'd2;
  localparam logic [1:0] ALUOP_OR   = 2'd3;

  // ALU operand B select
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_SEXT = 2'b10;
  localparam logic [1:0] SRCB_ZEXT = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_sig_t;

  // True for the eight defined opcodes
  function automatic logic is_legal_op(input logic [3:0] op);
    return (op <= OP_ORI);
  endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// State-to-control decode for the multicycle control FSM. Outputs are
// Moore-style from the current state, except the DECODE-cycle illegal
// opcode flag, which looks at the live opcode. mem_go gates the FETCH
// register loads while memory is still busy.
module ctrl_out_decode
  import ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [3:0] op_q,
  input  logic [3:0] opcode,
  input  logic       mem_go,
  output ctrl_sig_t  sig,
  output logic       illegal_op
);

  // Drive every datapath enable and select from the current state
  always_comb begin
    sig           = '0;
    sig.alu_src_b = SRCB_REG;
    sig.alu_op    = ALUOP_ADD;
    sig.pc_source = PCSRC_ALU;
    illegal_op    = 1'b0;
    case (state)
      S_FETCH: begin
        sig.mem_read  = 1'b1;
        sig.ir_write  = mem_go;
        sig.pc_write  = mem_go;
        sig.alu_src_b = SRCB_ONE;
        sig.alu_op    = ALUOP_ADD;
      end
      S_DECODE: begin
        sig.alu_src_b = SRCB_SEXT;
        sig.alu_op    = ALUOP_ADD;
        illegal_op    = !is_legal_op(opcode);
      end
      S_MEM_ADDR: begin
        sig.alu_src_a = 1'b1;
        sig.alu_src_b = SRCB_SEXT;
        sig.alu_op    = ALUOP_ADD;
      end
      S_MEM_RD: begin
        sig.iord     = 1'b1;
        sig.mem_read = 1'b1;
      end
      S_MEM_WB: begin
        sig.mem_to_reg = 1'b1;
        sig.reg_write  = 1'b1;
        sig.reg_dst    = 1'b0;
      end
      S_MEM_WR: begin
        sig.iord      = 1'b1;
        sig.mem_write = 1'b1;
      end
      S_R_EXEC: begin
        sig.alu_src_a = 1'b1;
        sig.alu_src_b = SRCB_REG;
        sig.alu_op    = ALUOP_FUNC;
      end
      S_I_EXEC: begin
        sig.alu_src_a = 1'b1;
        if (op_q == OP_ORI) begin
          sig.alu_src_b = SRCB_ZEXT;
          sig.alu_op    = ALUOP_OR;
        end else begin
          sig.alu_src_b = SRCB_SEXT;
          sig.alu_op    = ALUOP_ADD;
        end
      end
      S_ALU_WB: begin
        sig.reg_write  = 1'b1;
        sig.mem_to_reg = 1'b0;
        sig.reg_dst    = (op_q == OP_RTYPE);
      end
      S_BRANCH: begin
        sig.alu_src_a     = 1'b1;
        sig.alu_src_b     = SRCB_REG;
        sig.alu_op        = ALUOP_SUB;
        sig.pc_source     = PCSRC_ALUOUT;
        sig.pc_write_cond = 1'b1;
      end
      S_JUMP: begin
        sig.pc_source = PCSRC_JUMP;
        sig.pc_write  = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the 16-bit multicycle datapath. Holds the state,
// the opcode latched in DECODE and the bne flag; output decode lives in
// ctrl_out_decode. Optional build macro MULTICYCLE_MEM_WAIT_EN makes
// FETCH, MEM_RD and MEM_WR wait for mem_ready; without it those states
// always take exactly one cycle and mem_ready is ignored.
module multicycle_control_fsm
  import ctrl_pkg::*;
#(
  parameter int OPW = OPCODE_W,
  parameter int STW = STATE_W
)
(
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  input  logic           mem_ready,
  output logic           pc_en,
  output logic           iord,
  output logic           mem_read,
  output logic           mem_write,
  output logic           ir_write,
  output logic           mem_to_reg,
  output logic           reg_write,
  output logic           reg_dst,
  output logic           alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic [1:0]     alu_op,
  output logic [1:0]     pc_source,
  output logic           illegal_op,
  output logic [STW-1:0] state
);

  state_t     state_q;
  state_t     state_d;
  logic [3:0] opcode4;
  logic [3:0] op_q;
  logic       bne_q;
  logic       mem_go;
  ctrl_sig_t  sig;

  assign opcode4 = 4'(opcode);

`ifdef MULTICYCLE_MEM_WAIT_EN
  assign mem_go = mem_ready;
`else
  logic mem_ready_unused;
  assign mem_ready_unused = mem_ready;
  assign mem_go = 1'b1;
`endif

  // State register plus the opcode and bne flag captured in DECODE
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RST;
      op_q    <= '0;
      bne_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        op_q  <= opcode4;
        bne_q <= (opcode4 == OP_BNE);
      end
    end
  end

  // Next-state selection; memory states stall until mem_go
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:      state_d = S_FETCH;
      S_FETCH:    state_d = mem_go ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode4)
          OP_RTYPE:       state_d = S_R_EXEC;
          OP_ADDI, OP_ORI: state_d = S_I_EXEC;
          OP_LW, OP_SW:   state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:           state_d = S_JUMP;
          default:        state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR: state_d = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_d = mem_go ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:   state_d = S_FETCH;
      S_MEM_WR:   state_d = mem_go ? S_FETCH : S_MEM_WR;
      S_R_EXEC:   state_d = S_ALU_WB;
      S_I_EXEC:   state_d = S_ALU_WB;
      S_ALU_WB:   state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  ctrl_out_decode u_out_decode (
    .state      (state_q),
    .op_q       (op_q),
    .opcode     (opcode4),
    .mem_go     (mem_go),
    .sig        (sig),
    .illegal_op (illegal_op)
  );

  assign pc_en      = sig.pc_write | (sig.pc_write_cond & (zero ^ bne_q));
  assign iord       = sig.iord;
  assign mem_read   = sig.mem_read;
  assign mem_write  = sig.mem_write;
  assign ir_write   = sig.ir_write;
  assign mem_to_reg = sig.mem_to_reg;
  assign reg_write  = sig.reg_write;
  assign reg_dst    = sig.reg_dst;
  assign alu_src_a  = sig.alu_src_a;
  assign alu_src_b  = sig.alu_src_b;
  assign alu_op     = sig.alu_op;
  assign pc_source  = sig.pc_source;
  assign state      = STW'(state_q);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm. Each queue entry carries
// the inputs for one cycle together with the state and output word
// expected during that cycle.
module tb_multicycle_control_fsm;

  localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_MEM_ADDR = 4'd2,
                         ST_MEM_RD = 4'd3, ST_MEM_WB = 4'd4, ST_MEM_WR = 4'd5,
                         ST_R_EXEC = 4'd6, ST_ALU_WB = 4'd7, ST_BRANCH = 4'd8,
                         ST_JUMP = 4'd9, ST_I_EXEC = 4'd10, ST_RST = 4'd15;

  localparam logic [15:0] PCEN = 16'h8000, IORD = 16'h4000, MRD = 16'h2000,
                          MWR = 16'h1000, IRW = 16'h0800, M2R = 16'h0400,
                          RW = 16'h0200, RDST = 16'h0100, SRCA = 16'h0080,
                          ILL = 16'h0001, NONE = 16'h0000;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg;
  logic       reg_write, reg_dst, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;
  logic [15:0] obs;

  int checks = 0;
  int passes = 0;

  typedef struct {
    string       tag;
    logic [3:0]  st;
    logic [15:0] outs;
    logic [3:0]  op;
    logic        z;
    logic        rst;
    logic        rdy;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  multicycle_control_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_en      (pc_en),
    .iord       (iord),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_source  (pc_source),
    .illegal_op (illegal_op),
    .state      (state)
  );

  assign obs = {pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_write,
                reg_dst, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op};

  function automatic logic [15:0] fsrcb(input logic [1:0] v);
    return {9'b0, v, 5'b0};
  endfunction

  function automatic logic [15:0] faop(input logic [1:0] v);
    return {11'b0, v, 3'b0};
  endfunction

  function automatic logic [15:0] fpcs(input logic [1:0] v);
    return {13'b0, v, 1'b0};
  endfunction

  function automatic void push(input string tag, input logic [3:0] st, input logic [15:0] outs,
                               input logic [3:0] op, input logic z, input logic r, input logic rdy);
    exp_t e;
    e.tag = tag; e.st = st; e.outs = outs; e.op = op; e.z = z; e.rst = r; e.rdy = rdy;
    sb_q.push_back(e);
  endfunction

  // Queue the cycles of one complete instruction starting from FETCH
  function automatic void push_instr(input string tag, input logic [3:0] op, input logic z,
                                     input logic rdy);
    logic [15:0] dec;
    dec = (op >= 4'd8) ? (fsrcb(2'b10) | ILL) : fsrcb(2'b10);
    push({tag, "/fetch"}, ST_FETCH, PCEN | MRD | IRW | fsrcb(2'b01), op, z, 1'b0, rdy);
    push({tag, "/decode"}, ST_DECODE, dec, op, z, 1'b0, rdy);
    case (op)
      4'd0: begin
        push({tag, "/rexec"}, ST_R_EXEC, SRCA | faop(2'd2), op, z, 1'b0, rdy);
        push({tag, "/aluwb"}, ST_ALU_WB, RW | RDST, op, z, 1'b0, rdy);
      end
      4'd1: begin
        push({tag, "/iexec"}, ST_I_EXEC, SRCA | fsrcb(2'b10), op, z, 1'b0, rdy);
        push({tag, "/aluwb"}, ST_ALU_WB, RW, op, z, 1'b0, rdy);
      end
      4'd7: begin
        push({tag, "/iexec"}, ST_I_EXEC, SRCA | fsrcb(2'b11) | faop(2'd3), op, z, 1'b0, rdy);
        push({tag, "/aluwb"}, ST_ALU_WB, RW, op, z, 1'b0, rdy);
      end
      4'd2: begin
        push({tag, "/maddr"}, ST_MEM_ADDR, SRCA | fsrcb(2'b10), op, z, 1'b0, rdy);
        push({tag, "/memrd"}, ST_MEM_RD, IORD | MRD, op, z, 1'b0, rdy);
        push({tag, "/memwb"}, ST_MEM_WB, M2R | RW, op, z, 1'b0, rdy);
      end
      4'd3: begin
        push({tag, "/maddr"}, ST_MEM_ADDR, SRCA | fsrcb(2'b10), op, z, 1'b0, rdy);
        push({tag, "/memwr"}, ST_MEM_WR, IORD | MWR, op, z, 1'b0, rdy);
      end
      4'd4: push({tag, "/branch"}, ST_BRANCH, SRCA | faop(2'd1) | fpcs(2'b01) | (z ? PCEN : NONE),
                 op, z, 1'b0, rdy);
      4'd5: push({tag, "/branch"}, ST_BRANCH, SRCA | faop(2'd1) | fpcs(2'b01) | (z ? NONE : PCEN),
                 op, z, 1'b0, rdy);
      4'd6: push({tag, "/jump"}, ST_JUMP, PCEN | fpcs(2'b10), op, z, 1'b0, rdy);
      default: begin
      end
    endcase
  endfunction

  task automatic test_reset();
    exp_t e;
    push("rst/hold0", ST_RST, NONE, 4'd6, 1'b0, 1'b1, 1'b1);
    push("rst/hold1", ST_RST, NONE, 4'd6, 1'b0, 1'b1, 1'b1);
    push("rst/release", ST_RST, NONE, 4'd6, 1'b0, 1'b0, 1'b1);
    push_instr("rst_j", 4'd6, 1'b0, 1'b1);
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      opcode = e.op; zero = e.z; reset = e.rst; mem_ready = e.rdy;
      #1;
      checks++;
      if ({state, obs} !== {e.st, e.outs})
        $display("[TB] FAIL %s: state=%0d outs=%h, expected state=%0d outs=%h",
                 e.tag, state, obs, e.st, e.outs);
      else
        passes++;
      @(negedge clk);
    end
  endtask

  task automatic test_instr(input string tag, input logic [3:0] op, input logic z);
    exp_t e;
    push_instr(tag, op, z, 1'b1);
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      opcode = e.op; zero = e.z; reset = e.rst; mem_ready = e.rdy;
      #1;
      checks++;
      if ({state, obs} !== {e.st, e.outs})
        $display("[TB] FAIL %s: state=%0d outs=%h, expected state=%0d outs=%h",
                 e.tag, state, obs, e.st, e.outs);
      else
        passes++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    push("rmid/fetch", ST_FETCH, PCEN | MRD | IRW | fsrcb(2'b01), 4'd2, 1'b0, 1'b0, 1'b1);
    push("rmid/decode", ST_DECODE, fsrcb(2'b10), 4'd2, 1'b0, 1'b0, 1'b1);
    push("rmid/maddr", ST_MEM_ADDR, SRCA | fsrcb(2'b10), 4'd2, 1'b0, 1'b0, 1'b1);
    push("rmid/memrd", ST_MEM_RD, IORD | MRD, 4'd2, 1'b0, 1'b1, 1'b1);
    push("rmid/rst", ST_RST, NONE, 4'd2, 1'b0, 1'b0, 1'b1);
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      opcode = e.op; zero = e.z; reset = e.rst; mem_ready = e.rdy;
      #1;
      checks++;
      if ({state, obs} !== {e.st, e.outs})
        $display("[TB] FAIL %s: state=%0d outs=%h, expected state=%0d outs=%h",
                 e.tag, state, obs, e.st, e.outs);
      else
        passes++;
      @(negedge clk);
    end
  endtask

  task automatic test_mem_wait();
    exp_t e;
`ifdef MULTICYCLE_MEM_WAIT_EN
    for (int i = 0; i < 3; i++)
      push($sformatf("wait/fetch%0d", i), ST_FETCH, MRD | fsrcb(2'b01), 4'd3, 1'b0, 1'b0, 1'b0);
    push("wait/fetch_go", ST_FETCH, PCEN | MRD | IRW | fsrcb(2'b01), 4'd3, 1'b0, 1'b0, 1'b1);
    push("wait/decode", ST_DECODE, fsrcb(2'b10), 4'd3, 1'b0, 1'b0, 1'b1);
    push("wait/maddr", ST_MEM_ADDR, SRCA | fsrcb(2'b10), 4'd3, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++)
      push($sformatf("wait/memwr%0d", i), ST_MEM_WR, IORD | MWR, 4'd3, 1'b0, 1'b0, 1'b0);
    push("wait/memwr_go", ST_MEM_WR, IORD | MWR, 4'd3, 1'b0, 1'b0, 1'b1);
`else
    push_instr("nordy_lw", 4'd2, 1'b0, 1'b0);
    push_instr("nordy_sw", 4'd3, 1'b0, 1'b0);
`endif
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      opcode = e.op; zero = e.z; reset = e.rst; mem_ready = e.rdy;
      #1;
      checks++;
      if ({state, obs} !== {e.st, e.outs})
        $display("[TB] FAIL %s: state=%0d outs=%h, expected state=%0d outs=%h",
                 e.tag, state, obs, e.st, e.outs);
      else
        passes++;
      @(negedge clk);
    end
    mem_ready = 1'b1;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [3:0] op;
    logic z;
    for (int i = 0; i < 20; i++) begin
      op = 4'($urandom_range(0, 15));
      z  = 1'($urandom_range(0, 1));
      push_instr($sformatf("b2b%0d_op%0d", i, op), op, z, 1'b1);
    end
    push("b2b/final_fetch", ST_FETCH, PCEN | MRD | IRW | fsrcb(2'b01), 4'd6, 1'b0, 1'b0, 1'b1);
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      opcode = e.op; zero = e.z; reset = e.rst; mem_ready = e.rdy;
      #1;
      checks++;
      if ({state, obs} !== {e.st, e.outs})
        $display("[TB] FAIL %s: state=%0d outs=%h, expected state=%0d outs=%h",
                 e.tag, state, obs, e.st, e.outs);
      else
        passes++;
      @(negedge clk);
    end
  endtask

  initial begin
    reset     = 1'b1;
    opcode    = 4'd0;
    zero      = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    $display("[TB] reset sequence");
    test_reset();
    $display("[TB] single instructions");
    test_instr("rtype", 4'd0, 1'b0);
    test_instr("addi", 4'd1, 1'b0);
    test_instr("lw", 4'd2, 1'b0);
    test_instr("sw", 4'd3, 1'b0);
    test_instr("beq_z1", 4'd4, 1'b1);
    test_instr("beq_z0", 4'd4, 1'b0);
    test_instr("bne_z0", 4'd5, 1'b0);
    test_instr("bne_z1", 4'd5, 1'b1);
    test_instr("j", 4'd6, 1'b1);
    test_instr("ori", 4'd7, 1'b0);
    test_instr("illegal12", 4'd12, 1'b0);
    test_instr("illegal15", 4'd15, 1'b1);
    $display("[TB] reset during MEM_RD");
    test_reset_mid();
    test_instr("after_rst_bne", 4'd5, 1'b0);
    $display("[TB] memory ready handling");
    test_mem_wait();
    $display("[TB] back-to-back random instructions");
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
